// File: rtl/multi_channel_breath_pwm.sv
// Multi-channel breathing-LED driver: one shared PWM carrier counter and
// CH_NUM triangle brightness ramps with per-channel off/solid/breath/blink modes.
module multi_channel_breath_pwm #(
  parameter int CH_NUM         = 4,
  parameter int CNT_NUM        = 3464,
  parameter int CW             = 12,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2*CH_NUM-1:0]   mode,
  output logic [CH_NUM-1:0]     led,
  output logic [CH_NUM-1:0]     peak
);

  localparam logic [CW-1:0]     TOP   = CW'(CNT_NUM);
  localparam logic [CW-1:0]     LAST  = CW'(CNT_NUM - 1);
  localparam int                STEP  = CNT_NUM / CH_NUM;
  localparam logic              POL   = (LED_ACTIVE_LOW != 0);
  localparam logic [CH_NUM-1:0] UNLIT = {CH_NUM{POL}};

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_SOLID  = 2'b01;
  localparam logic [1:0] MODE_BREATH = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     level [CH_NUM];
  logic [CH_NUM-1:0] dir_up;
  logic [CH_NUM-1:0] lit;
  logic              wrap;

  always_comb begin
    wrap = en && (cnt == LAST);
    lit  = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      unique case (mode[2*i +: 2])
        MODE_OFF:    lit[i] = 1'b0;
        MODE_SOLID:  lit[i] = 1'b1;
        MODE_BREATH: lit[i] = (cnt < level[i]);
        MODE_BLINK:  lit[i] = dir_up[i];
        default:     lit[i] = 1'b0;
      endcase
    end
  end

  // Shared carrier: frozen while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

  // Ramps keep running in every mode so a return to breath stays in phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        level[i]  <= CW'(i * STEP);
        dir_up[i] <= 1'b1;
      end
      peak <= '0;
    end else begin
      peak <= '0;
      if (wrap) begin
        for (int i = 0; i < CH_NUM; i++) begin
          if (dir_up[i]) begin
            if (level[i] == TOP) begin
              dir_up[i] <= 1'b0;
              peak[i]   <= 1'b1;
            end else begin
              level[i] <= level[i] + CW'(1);
            end
          end else begin
            if (level[i] == '0) begin
              dir_up[i] <= 1'b1;
            end else begin
              level[i] <= level[i] - CW'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= UNLIT;
    end else if (en) begin
      led <= lit ^ UNLIT;
    end else begin
      led <= UNLIT;
    end
  end

endmodule

// File: tb/tb_multi_channel_breath_pwm.sv
// Bench for multi_channel_breath_pwm: time-based triangle reference model,
// directed scenarios plus randomized mode/enable traffic.
module tb_multi_channel_breath_pwm;

  localparam int CH   = 4;
  localparam int N    = 4;
  localparam int W    = 3;
  localparam int L    = 2 * (N + 1);
  localparam int STEP = N / CH;

  logic           clk  = 1'b0;
  logic           rst  = 1'b1;
  logic           en   = 1'b0;
  logic [2*CH-1:0] mode = '0;
  logic [CH-1:0]  led;
  logic [CH-1:0]  peak;

  int total = 0;
  int bad   = 0;
  int t     = 0;
  int exp_low [L] = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0};

  // clock / reset
  always #5 clk = ~clk;

  multi_channel_breath_pwm #(
    .CH_NUM(CH), .CNT_NUM(N), .CW(W), .LED_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .led(led), .peak(peak)
  );

  // reference model: position of channel ch in the 2*(N+1)-period triangle
  function automatic int ramp_pos(int ch, int tt);
    return (ch * STEP + tt / N) % L;
  endfunction

  function automatic logic exp_lit(int ch, int tt, logic [1:0] m);
    int p;
    int lvl;
    p   = ramp_pos(ch, tt);
    lvl = (p <= N) ? p : (L - 1 - p);
    case (m)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return (tt % N) < lvl;
      default: return p <= N;
    endcase
  endfunction

  function automatic logic exp_peak(int ch, int tt);
    return ((tt % N) == N - 1) && (ramp_pos(ch, tt) == N);
  endfunction

  // driver: predict the outputs of the coming edge, then advance one clock
  task automatic tick(output logic [CH-1:0] el, output logic [CH-1:0] ep);
    el = '1;
    ep = '0;
    if (en) begin
      for (int i = 0; i < CH; i++) begin
        el[i] = ~exp_lit(i, t, mode[2*i +: 2]);
        ep[i] = exp_peak(i, t);
      end
    end
    @(posedge clk);
    #1;
    if (en) t++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    t   = 0;
  endtask

  task automatic test_reset();
    logic [CH-1:0] el, ep;
    rst  = 1'b1;
    en   = 1'b0;
    mode = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (led !== 4'b1111) begin bad++; $display("FAIL reset_led got=%b want=1111", led); end
    total++;
    if (peak !== 4'b0000) begin bad++; $display("FAIL reset_peak got=%b want=0000", peak); end
    rst  = 1'b0;
    en   = 1'b1;
    mode = 8'b10_10_10_10;
    t    = 0;
    for (int k = 0; k < N; k++) begin
      tick(el, ep);
      total++;
      if (led[0] !== 1'b1) begin bad++; $display("FAIL reset_ch0_dark k=%0d got=%b want=1", k, led[0]); end
      total++;
      if (led !== el) begin bad++; $display("FAIL reset_led_model t=%0d got=%b want=%b", t, led, el); end
      total++;
      if (peak !== ep) begin bad++; $display("FAIL reset_peak_model t=%0d got=%b want=%b", t, peak, ep); end
    end
  endtask

  task automatic test_breath(int nper);
    logic [CH-1:0] el, ep;
    int lowc;
    int per;
    lowc = 0;
    en   = 1'b1;
    mode = 8'b10_10_10_10;
    for (int k = 0; k < nper * N; k++) begin
      per = t / N;
      tick(el, ep);
      total++;
      if (led !== el) begin bad++; $display("FAIL breath_led t=%0d got=%b want=%b", t, led, el); end
      total++;
      if (peak !== ep) begin bad++; $display("FAIL breath_peak t=%0d got=%b want=%b", t, peak, ep); end
      if (led[0] == 1'b0) lowc++;
      if ((k % N) == N - 1) begin
        total++;
        if (lowc != exp_low[per % L]) begin
          bad++; $display("FAIL breath_duty per=%0d got=%0d want=%0d", per, lowc, exp_low[per % L]);
        end
        lowc = 0;
      end
    end
  endtask

  task automatic test_stagger();
    logic [CH-1:0] el, ep;
    int first0, first3, low3;
    do_reset();
    en = 1'b1;
    mode = 8'b10_10_10_10;
    first0 = -1; first3 = -1; low3 = 0;
    for (int k = 0; k < 6 * N; k++) begin
      tick(el, ep);
      total++;
      if (led !== el) begin bad++; $display("FAIL stagger_led t=%0d got=%b want=%b", t, led, el); end
      if (k < N && led[3] == 1'b0) low3++;
      if (peak[0] && first0 < 0) first0 = t;
      if (peak[3] && first3 < 0) first3 = t;
    end
    total++;
    if (low3 != 3) begin bad++; $display("FAIL stagger_ch3_duty got=%0d want=3", low3); end
    total++;
    if (first3 < 0 || first0 - first3 != 3 * N) begin
      bad++; $display("FAIL stagger_peak_lead got=%0d want=%0d", first0 - first3, 3 * N);
    end
  endtask

  task automatic test_modes();
    logic [CH-1:0] el, ep;
    int low3;
    low3 = 0;
    en   = 1'b1;
    mode = 8'b11_01_00_10;
    for (int k = 0; k < 2 * L * N; k++) begin
      tick(el, ep);
      total++;
      if (led[1] !== 1'b1) begin bad++; $display("FAIL modes_off t=%0d got=%b want=1", t, led[1]); end
      total++;
      if (led[2] !== 1'b0) begin bad++; $display("FAIL modes_solid t=%0d got=%b want=0", t, led[2]); end
      total++;
      if (led !== el) begin bad++; $display("FAIL modes_led t=%0d got=%b want=%b", t, led, el); end
      total++;
      if (peak !== ep) begin bad++; $display("FAIL modes_peak t=%0d got=%b want=%b", t, peak, ep); end
      if (led[3] == 1'b0) low3++;
    end
    total++;
    if (low3 != L * N) begin bad++; $display("FAIL modes_blink_low got=%0d want=%0d", low3, L * N); end
  endtask

  task automatic test_freeze();
    logic [CH-1:0] el, ep;
    en   = 1'b1;
    mode = 8'b10_10_10_10;
    repeat (10) tick(el, ep);
    en = 1'b0;
    for (int k = 0; k < 17; k++) begin
      tick(el, ep);
      total++;
      if (led !== 4'b1111) begin bad++; $display("FAIL freeze_led k=%0d got=%b want=1111", k, led); end
      total++;
      if (peak !== 4'b0000) begin bad++; $display("FAIL freeze_peak k=%0d got=%b want=0000", k, peak); end
    end
    en = 1'b1;
    for (int k = 0; k < L * N; k++) begin
      tick(el, ep);
      total++;
      if (led !== el) begin bad++; $display("FAIL resume_led t=%0d got=%b want=%b", t, led, el); end
      total++;
      if (peak !== ep) begin bad++; $display("FAIL resume_peak t=%0d got=%b want=%b", t, peak, ep); end
    end
  endtask

  task automatic test_async_reset();
    logic [CH-1:0] el, ep;
    en   = 1'b1;
    mode = 8'b01_01_10_01;
    repeat (13) tick(el, ep);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (led !== 4'b1111) begin bad++; $display("FAIL async_rst_led got=%b want=1111", led); end
    total++;
    if (peak !== 4'b0000) begin bad++; $display("FAIL async_rst_peak got=%b want=0000", peak); end
    test_reset();
    test_breath(L);
  endtask

  task automatic test_random();
    logic [CH-1:0] el, ep;
    for (int k = 0; k < 300; k++) begin
      mode = 8'($urandom);
      en   = ($urandom_range(0, 7) != 0);
      tick(el, ep);
      total++;
      if (led !== el) begin bad++; $display("FAIL random_led t=%0d got=%b want=%b", t, led, el); end
      total++;
      if (peak !== ep) begin bad++; $display("FAIL random_peak t=%0d got=%b want=%b", t, peak, ep); end
    end
  endtask

  initial begin
    test_reset();
    test_breath(2 * L);
    test_stagger();
    test_modes();
    test_freeze();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
